// File: rtl/menu_pkg.sv
// Shared MENU-core definitions: read-back FSM states, SDRAM geometry and the
// fill-pattern encoding used by both the fill and the read-back logic.
package menu_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFin} rb_state_e;

  localparam int unsigned MEM_ADDR_W = 25;
  localparam int unsigned MEM_DATA_W = 16;

  localparam logic PAT_ZERO = 1'b0;
  localparam logic PAT_ADDR = 1'b1;

endpackage

// File: rtl/sdram_readback_checker_if.sv
// SDRAM controller rd/ready port as seen by the read-back checker (master) and
// the sram controller (slave).
interface sdram_readback_checker_if import menu_pkg::*; #(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [1:0]        mem_wtbt;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wtbt,
    input  mem_dout, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wtbt,
    output mem_dout, mem_ready
  );
endinterface

// File: rtl/rb_pattern_gen.sv
// Expected fill word for a given address: all-zero or the low address bits.
module rb_pattern_gen import menu_pkg::*; #(
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic              pattern_i,
  input  logic [DATA_W-1:0] addr_i,
  output logic [DATA_W-1:0] exp_o
);
  always_comb begin
    exp_o = '0;
    if (pattern_i == PAT_ADDR) exp_o = addr_i;
  end
endmodule

// File: rtl/sdram_readback_checker.sv
// Sweeps SDRAM 0..LAST_ADDR one read at a time and compares each word with the
// fill pattern; reports pass/fail, saturating error count and first bad address.
module sdram_readback_checker import menu_pkg::*; #(
  parameter int unsigned       ADDR_W      = MEM_ADDR_W,
  parameter int unsigned       DATA_W      = MEM_DATA_W,
  parameter logic [ADDR_W-1:0] LAST_ADDR   = '1,
  parameter int unsigned       TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      pattern,
  sdram_readback_checker_if.master  mem,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [15:0]               err_count,
  output logic [ADDR_W-1:0]         first_err_addr
);
  localparam int unsigned       WaitW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYC - 1);

  rb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [15:0]       err_q, err_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic              pat_q, pat_d;
  logic [DATA_W-1:0] exp_word;
  logic              wait_expired;
  logic              last_word;

  rb_pattern_gen #(.DATA_W(DATA_W)) u_pattern_gen (
    .pattern_i (pat_q),
    .addr_i    (addr_q[DATA_W-1:0]),
    .exp_o     (exp_word)
  );

  assign wait_expired = (wait_q == WaitLast);
  assign last_word    = (addr_q == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StFin: if (start) state_d = StIssue;
      StIssue:       state_d = StWait;
      StWait: begin
        if (mem.mem_ready)     state_d = last_word ? StFin : StIssue;
        else if (wait_expired) state_d = StFin;
      end
      default:       state_d = StIdle;
    endcase
  end

  always_comb begin
    mem.mem_addr   = addr_q;
    mem.mem_rd     = (state_q == StIssue);
    mem.mem_wtbt   = 2'b11;
    busy           = (state_q == StIssue) || (state_q == StWait);
    done           = (state_q == StFin);
    pass           = (state_q == StFin) && (err_q == '0) && !timeout_q;
    timeout        = timeout_q;
    err_count      = err_q;
    first_err_addr = first_q;
  end

  always_comb begin
    addr_d    = addr_q;
    first_d   = first_q;
    err_d     = err_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    pat_d     = pat_q;
    unique case (state_q)
      StIdle, StFin: begin
        if (start) begin
          addr_d    = '0;
          first_d   = '0;
          err_d     = '0;
          timeout_d = 1'b0;
          pat_d     = pattern;
        end
      end
      StIssue: wait_d = '0;
      StWait: begin
        if (mem.mem_ready) begin
          if (mem.mem_dout != exp_word) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            // Count never returns to zero within a sweep, so zero marks the first error.
            if (err_q == '0) first_d = addr_q;
          end
          if (!last_word) addr_d = addr_q + 1'b1;
        end else if (wait_expired) begin
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      first_q   <= '0;
      err_q     <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      pat_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      first_q   <= first_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      pat_q     <= pat_d;
    end
  end
endmodule

// File: tb/tb_sdram_readback_checker.sv
// Directed bench: dut_a (16-bit data, 16 words) and dut_b (8-bit data, 260
// words, crosses the data-width wrap) against behavioural sram models.
module tb_sdram_readback_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, pattern_a = 1'b0, pattern_b = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sdram_readback_checker_if #(.ADDR_W(25), .DATA_W(16)) mif_a ();
  sdram_readback_checker_if #(.ADDR_W(12), .DATA_W(8))  mif_b ();

  logic        busy_a, done_a, pass_a, tmo_a, busy_b, done_b, pass_b, tmo_b;
  logic [15:0] err_a, err_b;
  logic [24:0] first_a;
  logic [11:0] first_b;

  sdram_readback_checker #(.ADDR_W(25), .DATA_W(16), .LAST_ADDR(25'd15), .TIMEOUT_CYC(64)) dut_a (
    .clk (clk), .reset (reset), .start (start_a), .pattern (pattern_a), .mem (mif_a),
    .busy (busy_a), .done (done_a), .pass (pass_a), .timeout (tmo_a),
    .err_count (err_a), .first_err_addr (first_a)
  );

  sdram_readback_checker #(.ADDR_W(12), .DATA_W(8), .LAST_ADDR(12'h103), .TIMEOUT_CYC(64)) dut_b (
    .clk (clk), .reset (reset), .start (start_b), .pattern (pattern_b), .mem (mif_b),
    .busy (busy_b), .done (done_b), .pass (pass_b), .timeout (tmo_b),
    .err_count (err_b), .first_err_addr (first_b)
  );

  // sram model A: fixed latency, optional dropped address, spurious-ready injection
  logic [15:0] mem_a [16];
  int          lat_a = 1, drop_a = -1, cnt_a = 0, rd_cnt_a = 0;
  logic        rdy_a = 1'b0, spur_a = 1'b0;
  logic [15:0] dq_a = '0, spur_d_a = '0;
  assign mif_a.mem_ready = rdy_a | spur_a;
  assign mif_a.mem_dout  = spur_a ? spur_d_a : dq_a;

  function automatic logic [15:0] word_a(input logic [24:0] a);
    return (a < 25'd16) ? mem_a[a[3:0]] : 16'h0;
  endfunction

  always @(posedge clk) begin
    rdy_a <= 1'b0;
    if (mif_a.mem_rd) rd_cnt_a <= rd_cnt_a + 1;
    if (cnt_a != 0) begin
      if (cnt_a == 1) begin
        rdy_a <= 1'b1;
        dq_a  <= word_a(mif_a.mem_addr);
      end
      cnt_a <= cnt_a - 1;
    end else if (mif_a.mem_rd && int'(mif_a.mem_addr) != drop_a) begin
      if (lat_a <= 1) begin
        rdy_a <= 1'b1;
        dq_a  <= word_a(mif_a.mem_addr);
      end else begin
        cnt_a <= lat_a - 1;
      end
    end
  end

  // sram model B: fixed or random (1..20) latency
  logic [7:0] mem_b [260];
  int         lat_b = 1, cnt_b = 0, rd_cnt_b = 0, nl_b = 1, eff_lat_b;
  bit         rand_lat_b = 1'b0;
  logic       rdy_b = 1'b0;
  logic [7:0] dq_b = '0;
  assign mif_b.mem_ready = rdy_b;
  assign mif_b.mem_dout  = dq_b;
  assign eff_lat_b       = rand_lat_b ? nl_b : lat_b;

  function automatic logic [7:0] word_b(input logic [11:0] a);
    return (a < 12'd260) ? mem_b[a] : 8'h0;
  endfunction

  always @(posedge clk) begin
    rdy_b <= 1'b0;
    nl_b  <= $urandom_range(20, 1);
    if (mif_b.mem_rd) rd_cnt_b <= rd_cnt_b + 1;
    if (cnt_b != 0) begin
      if (cnt_b == 1) begin
        rdy_b <= 1'b1;
        dq_b  <= word_b(mif_b.mem_addr);
      end
      cnt_b <= cnt_b - 1;
    end else if (mif_b.mem_rd) begin
      if (eff_lat_b <= 1) begin
        rdy_b <= 1'b1;
        dq_b  <= word_b(mif_b.mem_addr);
      end else begin
        cnt_b <= eff_lat_b - 1;
      end
    end
  end

  int n_total = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pulse_start(input bit sel_b);
    @(negedge clk);
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit sel_b, input int budget, input string tag);
    int i = 0;
    while (!(sel_b ? done_b : done_a) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, 32'(sel_b ? done_b : done_a), 32'd1);
  endtask

  task automatic wait_rd_a(input logic [24:0] a, input int budget, input string tag, output int t);
    int i = 0;
    while (!(mif_a.mem_rd && mif_a.mem_addr == a) && i < budget) begin
      @(negedge clk);
      i++;
    end
    t = cyc;
    check(tag, 32'(mif_a.mem_rd && mif_a.mem_addr == a), 32'd1);
  endtask

  initial begin
    int          base, t_rd, t_done, exp_err, exp_first;
    foreach (mem_a[i]) mem_a[i] = '0;
    foreach (mem_b[i]) mem_b[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_busy", 32'(busy_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_pass", 32'(pass_a), 0);
    check("rst_timeout", 32'(tmo_a), 0);
    check("rst_err", 32'(err_a), 0);
    check("rst_first", 32'(first_a), 0);
    check("rst_addr", 32'(mif_a.mem_addr), 0);
    check("rst_rd", 32'(mif_a.mem_rd), 0);

    // Spurious ready with bad data while idle
    base = rd_cnt_a;
    spur_d_a = 16'hDEAD;
    spur_a = 1'b1;
    @(negedge clk);
    spur_a = 1'b0;
    @(negedge clk);
    check("idle_spur_err", 32'(err_a), 0);
    check("idle_spur_busy", 32'(busy_a), 0);
    check("idle_spur_rd", 32'(rd_cnt_a - base), 0);

    // All-zero sweep; restart attempt and pattern flip while busy must be ignored
    pattern_a = 1'b0;
    base = rd_cnt_a;
    pulse_start(1'b0);
    check("t1_busy", 32'(busy_a), 1);
    check("t1_rd_first", 32'(mif_a.mem_rd), 1);
    check("t1_wtbt", 32'(mif_a.mem_wtbt), 32'h3);
    repeat (10) @(negedge clk);
    pattern_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0, 200, "t1_done");
    pattern_a = 1'b0;
    check("t1_pass", 32'(pass_a), 1);
    check("t1_err", 32'(err_a), 0);
    check("t1_rd_count", 32'(rd_cnt_a - base), 16);
    check("t1_busy_end", 32'(busy_a), 0);
    check("t1_timeout", 32'(tmo_a), 0);

    // Two bad words
    mem_a[5] = 16'h0001;
    mem_a[9] = 16'h8000;
    pulse_start(1'b0);
    wait_done(1'b0, 200, "t2_done");
    check("t2_err", 32'(err_a), 2);
    check("t2_first", 32'(first_a), 5);
    check("t2_pass", 32'(pass_a), 0);
    base = rd_cnt_a;
    spur_a = 1'b1;
    @(negedge clk);
    spur_a = 1'b0;
    repeat (2) @(negedge clk);
    check("fin_spur_err", 32'(err_a), 2);
    check("fin_spur_rd", 32'(rd_cnt_a - base), 0);
    mem_a[5] = '0;
    mem_a[9] = '0;

    // Address pattern across the 8-bit wrap (0xFF -> 0x00 at address 0x100)
    foreach (mem_b[i]) mem_b[i] = 8'(i);
    pattern_b = 1'b1;
    base = rd_cnt_b;
    pulse_start(1'b1);
    wait_done(1'b1, 2000, "t3_done");
    check("t3_pass", 32'(pass_b), 1);
    check("t3_err", 32'(err_b), 0);
    check("t3_rd_count", 32'(rd_cnt_b - base), 260);

    // Missing ready at address 7
    drop_a = 7;
    base = rd_cnt_a;
    pulse_start(1'b0);
    wait_rd_a(25'd7, 100, "t4_rd7", t_rd);
    wait_done(1'b0, 200, "t4_done");
    t_done = cyc;
    // rd seen in the cycle before WAIT entry, hence 64 + 1
    check("t4_latency", 32'(t_done - t_rd), 65);
    check("t4_timeout", 32'(tmo_a), 1);
    check("t4_addr", 32'(mif_a.mem_addr), 7);
    check("t4_pass", 32'(pass_a), 0);
    repeat (10) @(negedge clk);
    check("t4_rd_count", 32'(rd_cnt_a - base), 8);
    check("t4_done_held", 32'(done_a), 1);
    drop_a = -1;

    // Reset while waiting on address 3; its late ready carries bad data
    lat_a = 10;
    mem_a[3] = 16'h1234;
    pulse_start(1'b0);
    wait_rd_a(25'd3, 100, "t5_rd3", t_rd);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    base = rd_cnt_a;
    check("t5_busy_now", 32'(busy_a), 0);
    check("t5_addr_now", 32'(mif_a.mem_addr), 0);
    repeat (15) @(negedge clk);
    check("t5_busy", 32'(busy_a), 0);
    check("t5_done", 32'(done_a), 0);
    check("t5_pass", 32'(pass_a), 0);
    check("t5_timeout", 32'(tmo_a), 0);
    check("t5_err", 32'(err_a), 0);
    check("t5_first", 32'(first_a), 0);
    check("t5_rd_count", 32'(rd_cnt_a - base), 0);
    lat_a = 1;
    mem_a[3] = '0;
    base = rd_cnt_a;
    pulse_start(1'b0);
    check("t5_rerun_addr", 32'(mif_a.mem_addr), 0);
    wait_done(1'b0, 200, "t5_rerun_done");
    check("t5_rerun_pass", 32'(pass_a), 1);
    check("t5_rerun_rd", 32'(rd_cnt_a - base), 16);

    // Random latency and random corrupted words, scoreboarded
    exp_err = 0;
    exp_first = 0;
    foreach (mem_b[i]) mem_b[i] = ($urandom_range(7, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h0;
    mem_b[10] = 8'h5A;
    foreach (mem_b[i]) begin
      if (mem_b[i] != 8'h0) begin
        if (exp_err == 0) exp_first = i;
        exp_err++;
      end
    end
    rand_lat_b = 1'b1;
    pattern_b = 1'b0;
    base = rd_cnt_b;
    pulse_start(1'b1);
    wait_done(1'b1, 10000, "t7_done");
    check("t7_err", 32'(err_b), 32'(exp_err));
    check("t7_first", 32'(first_b), 32'(exp_first));
    check("t7_pass", 32'(pass_b), 0);
    check("t7_rd_count", 32'(rd_cnt_b - base), 260);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
